// File: rtl/stack_judge.sv
// Stacking game judge: moves a block mask left/right at a programmable pace,
// and on a button press checks overlap with the previously placed row.
module stack_judge #(
  parameter int unsigned PRESCALE   = 50000,
  parameter logic [7:0]  START_MASK = 8'b1110_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] period,
  input  logic       press,
  output logic       stacked,
  output logic       game_over,
  output logic [7:0] row_pattern,
  output logic [7:0] base_pattern,
  output logic [3:0] level
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_JUDGE,
    S_OVER
  } state_t;

  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } dir_t;

  localparam logic [19:0] LP_PRESC_MAX = 20'(PRESCALE - 1);

  state_t      r_state, w_state_nxt;
  dir_t        r_dir, w_dir_nxt, w_dir_step;
  logic [19:0] r_presc, w_presc_nxt;
  logic [7:0]  r_step, w_step_nxt;
  logic [7:0]  r_row, w_row_nxt, w_row_step;
  logic [7:0]  r_base, w_base_nxt;
  logic [3:0]  r_level, w_level_nxt;
  logic        r_stacked, w_stacked_nxt;
  logic        r_game_over, w_game_over_nxt;

  logic        w_tick;
  logic [7:0]  w_thresh;
  logic        w_step_due;
  logic [7:0]  w_overlap;

  assign w_tick     = (r_state == S_MOVE) && (r_presc == LP_PRESC_MAX);
  // period 0 behaves like period 1; >= lets a shrinking period fire on the next tick
  assign w_thresh   = (period == 8'd0) ? 8'd0 : (period - 8'd1);
  assign w_step_due = (r_step >= w_thresh);
  assign w_overlap  = r_row & r_base;

  assign stacked      = r_stacked;
  assign game_over    = r_game_over;
  assign row_pattern  = r_row;
  assign base_pattern = r_base;
  assign level        = r_level;

  // State and registered-output update, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dir       <= DIR_RIGHT;
      r_presc     <= '0;
      r_step      <= '0;
      r_row       <= '0;
      r_base      <= '1;
      r_level     <= '0;
      r_stacked   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_presc     <= w_presc_nxt;
      r_step      <= w_step_nxt;
      r_row       <= w_row_nxt;
      r_base      <= w_base_nxt;
      r_level     <= w_level_nxt;
      r_stacked   <= w_stacked_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (press) w_state_nxt = S_MOVE;
      S_MOVE:  if (press) w_state_nxt = S_JUDGE;
      S_JUDGE: w_state_nxt = (w_overlap != 8'd0) ? S_MOVE : S_OVER;
      S_OVER:  if (press) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Mask and direction a step would produce; a full row never moves or turns
  always_comb begin
    w_row_step = r_row;
    w_dir_step = r_dir;
    if (r_row != 8'hFF) begin
      if (r_dir == DIR_RIGHT) begin
        if (r_row[0]) begin
          w_dir_step = DIR_LEFT;
          w_row_step = r_row << 1;
        end else begin
          w_row_step = r_row >> 1;
        end
      end else begin
        if (r_row[7]) begin
          w_dir_step = DIR_RIGHT;
          w_row_step = r_row >> 1;
        end else begin
          w_row_step = r_row << 1;
        end
      end
    end
  end

  // Next values of the datapath registers and outputs
  always_comb begin
    w_dir_nxt       = r_dir;
    w_presc_nxt     = r_presc;
    w_step_nxt      = r_step;
    w_row_nxt       = r_row;
    w_base_nxt      = r_base;
    w_level_nxt     = r_level;
    w_stacked_nxt   = 1'b0;
    w_game_over_nxt = r_game_over;
    case (r_state)
      S_IDLE: begin
        if (press) begin
          w_row_nxt   = START_MASK;
          w_base_nxt  = '1;
          w_dir_nxt   = DIR_RIGHT;
          w_presc_nxt = '0;
          w_step_nxt  = '0;
          w_level_nxt = '0;
        end
      end
      S_MOVE: begin
        // a press freezes the pattern so the judge sees exactly what was shown
        if (!press) begin
          w_presc_nxt = w_tick ? 20'd0 : (r_presc + 20'd1);
          if (w_tick) begin
            if (w_step_due) begin
              w_step_nxt = '0;
              w_row_nxt  = w_row_step;
              w_dir_nxt  = w_dir_step;
            end else begin
              w_step_nxt = r_step + 8'd1;
            end
          end
        end
      end
      S_JUDGE: begin
        if (w_overlap != 8'd0) begin
          w_row_nxt     = w_overlap;
          w_base_nxt    = w_overlap;
          w_level_nxt   = (r_level == 4'd15) ? r_level : (r_level + 4'd1);
          w_stacked_nxt = 1'b1;
          w_presc_nxt   = '0;
          w_step_nxt    = '0;
        end else begin
          w_game_over_nxt = 1'b1;
        end
      end
      S_OVER: begin
        if (press) begin
          w_game_over_nxt = 1'b0;
          w_row_nxt       = '0;
          w_level_nxt     = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_judge.sv
// Self-checking bench for stack_judge: directed vector table, hand sequences
// for timing corners, and randomized play against a behavioural model.
module tb_stack_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic       press;
  logic [7:0] period;
  logic       stacked, game_over;
  logic [7:0] row_pattern, base_pattern;
  logic [3:0] level;
  logic       f_stacked, f_game_over;
  logic [7:0] f_row, f_base;
  logic [3:0] f_level;

  int checks = 0;
  int errors = 0;

  stack_judge #(.PRESCALE(1), .START_MASK(8'b1110_0000)) dut (
    .clk(clk), .rst(rst), .period(period), .press(press),
    .stacked(stacked), .game_over(game_over), .row_pattern(row_pattern),
    .base_pattern(base_pattern), .level(level)
  );

  // full-width start mask: must never move
  stack_judge #(.PRESCALE(2), .START_MASK(8'hFF)) dut_full (
    .clk(clk), .rst(rst), .period(period), .press(press),
    .stacked(f_stacked), .game_over(f_game_over), .row_pattern(f_row),
    .base_pattern(f_base), .level(f_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int row, input int base, input int lvl,
                           input int stk, input int go);
    check({tag, ".row"}, 32'(row_pattern), 32'(row));
    check({tag, ".base"}, 32'(base_pattern), 32'(base));
    check({tag, ".level"}, 32'(level), 32'(lvl));
    check({tag, ".stacked"}, 32'(stacked), 32'(stk));
    check({tag, ".game_over"}, 32'(game_over), 32'(go));
  endtask

  task automatic do_reset();
    press = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cyc(input bit p);
    press = p;
    @(posedge clk);
    #1;
    press = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {PH_IDLE, PH_MOVE, PH_JUDGE, PH_LOST} phase_t;
  phase_t m_phase;
  int     m_row, m_base, m_level, m_units, m_sub;
  bit     m_right, m_stk, m_lost;
  localparam int M_PRESCALE = 1;

  function automatic void model_reset();
    m_phase = PH_IDLE; m_row = 0; m_base = 255; m_level = 0;
    m_units = 0; m_sub = 0; m_right = 1; m_stk = 0; m_lost = 0;
  endfunction

  function automatic void model_move_block();
    if (m_row == 255) return;
    if (m_right) begin
      if (m_row % 2 == 1) begin m_right = 0; m_row = (m_row * 2) % 256; end
      else m_row = m_row / 2;
    end else begin
      if (m_row >= 128) begin m_right = 1; m_row = m_row / 2; end
      else m_row = (m_row * 2) % 256;
    end
  endfunction

  function automatic void model_next(input bit p, input int per);
    int ov;
    int need;
    m_stk = 0;
    case (m_phase)
      PH_IDLE: if (p) begin
        m_phase = PH_MOVE; m_row = 8'hE0; m_base = 255; m_right = 1;
        m_units = 0; m_sub = 0; m_level = 0;
      end
      PH_MOVE: begin
        if (p) m_phase = PH_JUDGE;
        else begin
          m_sub++;
          if (m_sub == M_PRESCALE) begin
            m_sub = 0;
            m_units++;
            need = (per < 1) ? 1 : per;
            if (m_units >= need) begin
              m_units = 0;
              model_move_block();
            end
          end
        end
      end
      PH_JUDGE: begin
        ov = m_row & m_base;
        if (ov != 0) begin
          m_row = ov; m_base = ov;
          m_level = (m_level >= 15) ? 15 : m_level + 1;
          m_stk = 1; m_units = 0; m_sub = 0; m_phase = PH_MOVE;
        end else begin
          m_phase = PH_LOST; m_lost = 1;
        end
      end
      PH_LOST: if (p) begin
        m_phase = PH_IDLE; m_lost = 0; m_row = 0; m_level = 0;
      end
      default: ;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         press;
    logic [7:0] period;
    logic [7:0] row;
    logic [7:0] base;
    logic [3:0] lvl;
    bit         stk;
    bit         go;
  } vec_t;

  vec_t vecs[35];

  initial begin
    int n;
    logic [7:0] prev;
    logic [7:0] plist[6];
    plist[0] = 8'd0; plist[1] = 8'd1; plist[2] = 8'd2;
    plist[3] = 8'd3; plist[4] = 8'd5; plist[5] = 8'd7;

    vecs[0]  = '{1'b1, 8'd2, 8'hE0, 8'hFF, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'd2, 8'hE0, 8'hFF, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'd2, 8'h70, 8'hFF, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'd2, 8'h70, 8'hFF, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'd2, 8'h38, 8'hFF, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'd2, 8'h38, 8'hFF, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'd2, 8'h38, 8'h38, 4'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'd2, 8'h38, 8'h38, 4'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'd2, 8'h1C, 8'h38, 4'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'd2, 8'h1C, 8'h38, 4'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'd2, 8'h18, 8'h18, 4'd2, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'd2, 8'h18, 8'h18, 4'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'd2, 8'h18, 8'h18, 4'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'd2, 8'h18, 8'h18, 4'd3, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'd2, 8'h18, 8'h18, 4'd3, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 8'd2, 8'h0C, 8'h18, 4'd3, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'd2, 8'h0C, 8'h18, 4'd3, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'd2, 8'h06, 8'h18, 4'd3, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 8'd2, 8'h06, 8'h18, 4'd3, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 8'd2, 8'h03, 8'h18, 4'd3, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 8'd2, 8'h03, 8'h18, 4'd3, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 8'd2, 8'h03, 8'h18, 4'd3, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 8'd2, 8'h03, 8'h18, 4'd3, 1'b0, 1'b1};
    vecs[23] = '{1'b1, 8'd2, 8'h00, 8'h18, 4'd0, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 8'd2, 8'h00, 8'h18, 4'd0, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 8'd0, 8'hE0, 8'hFF, 4'd0, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 8'd0, 8'h70, 8'hFF, 4'd0, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 8'd0, 8'h38, 8'hFF, 4'd0, 1'b0, 1'b0};
    vecs[28] = '{1'b1, 8'd0, 8'h38, 8'hFF, 4'd0, 1'b0, 1'b0};
    vecs[29] = '{1'b1, 8'd0, 8'h38, 8'h38, 4'd1, 1'b1, 1'b0};
    vecs[30] = '{1'b0, 8'd0, 8'h1C, 8'h38, 4'd1, 1'b0, 1'b0};
    vecs[31] = '{1'b0, 8'd0, 8'h0E, 8'h38, 4'd1, 1'b0, 1'b0};
    vecs[32] = '{1'b0, 8'd0, 8'h07, 8'h38, 4'd1, 1'b0, 1'b0};
    vecs[33] = '{1'b0, 8'd0, 8'h0E, 8'h38, 4'd1, 1'b0, 1'b0};
    vecs[34] = '{1'b0, 8'd0, 8'h1C, 8'h38, 4'd1, 1'b0, 1'b0};

    // reset values and idle hold
    rst = 1'b1; press = 1'b0; period = 8'd2;
    #12;
    check_all("reset", 0, 255, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0);
      check_all("idle_hold", 0, 255, 0, 0, 0);
    end

    // directed table
    for (int i = 0; i < 35; i++) begin
      period = vecs[i].period;
      cyc(vecs[i].press);
      check_all($sformatf("vec%0d", i), vecs[i].row, vecs[i].base, vecs[i].lvl,
                vecs[i].stk, vecs[i].go);
    end

    // period 200: 200 clocks between steps
    do_reset();
    period = 8'd200;
    cyc(1'b1);
    check("p200.start", 32'(row_pattern), 32'hE0);
    for (int g = 0; g < 2; g++) begin
      prev = row_pattern;
      n = 0;
      while (row_pattern == prev && n < 1000) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("p200.gap%0d", g), 32'(n), 32'd200);
    end

    // level saturates at 15; stacked one cycle per success
    do_reset();
    period = 8'd200;
    cyc(1'b1);
    for (int k = 0; k < 17; k++) begin
      cyc(1'b1);
      check("sat.judge_stk", 32'(stacked), 32'd0);
      cyc(1'b0);
      check("sat.stacked", 32'(stacked), 32'd1);
      check("sat.level", 32'(level), 32'((k + 1 > 15) ? 15 : k + 1));
    end

    // full row never moves
    do_reset();
    period = 8'd0;
    cyc(1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0);
      check("full.row", 32'(f_row), 32'hFF);
    end

    // asynchronous reset during JUDGE suppresses the pulse
    do_reset();
    period = 8'd2;
    cyc(1'b1);
    cyc(1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all("rst_judge", 0, 255, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0);
      check("rst_judge.stk", 32'(stacked), 32'd0);
      check("rst_judge.row", 32'(row_pattern), 32'd0);
    end

    // randomized play against the model
    do_reset();
    model_reset();
    period = 8'd2;
    for (int c = 0; c < 4000; c++) begin
      bit p;
      p = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) period = plist[$urandom_range(0, 5)];
      model_next(p, int'(period));
      cyc(p);
      check_all("rand", m_row, m_base, m_level, int'(m_stk), int'(m_lost));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
